// File: rtl/ring_pkg.sv
// Shared constants for the ring-drawing datapath: screen geometry,
// direction-ROM scaling and the plotter state encoding.
package ring_pkg;

    localparam int CENTRE_X    = 80;
    localparam int CENTRE_Y    = 60;
    localparam int SCREEN_XMAX = 159;
    localparam int SCREEN_YMAX = 119;

    // Direction vectors are stored scaled by 16, so products shift right by 4.
    localparam int DIR_SCALE   = 16;
    localparam int SCALE_SHIFT = 4;

    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PLOT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ring_line_plotter_if.sv
// Controller-to-plotter handshake plus the pixel stream towards the VGA adapter.
interface ring_line_plotter_if
    import ring_pkg::*;
#(
    parameter int LEN_W = 6
);
    logic                calc;
    logic                draw;
    logic [3:0]          line_number;
    logic [LEN_W-1:0]    length;
    logic [COLOUR_W-1:0] colour_in;
    logic                busy;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;

    modport master (
        output calc, draw, line_number, length, colour_in,
        input  busy, x, y, colour_out, plot
    );

    modport slave (
        input  calc, draw, line_number, length, colour_in,
        output busy, x, y, colour_out, plot
    );
endinterface

// File: rtl/line_dir_rom.sv
// 16-direction unit-vector table, scaled by 16, screen y pointing down.
// Index k selects the angle 22.5*k degrees counter-clockwise from +x.
module line_dir_rom (
    input  logic [3:0]        k,
    output logic signed [5:0] dx,
    output logic signed [5:0] dy
);

    // Pure lookup of the scaled cosine / negated sine for each direction
    always_comb begin
        dx = 6'sd0;
        dy = 6'sd0;
        case (k)
            4'd0:  begin dx =  6'sd16; dy =  6'sd0;  end
            4'd1:  begin dx =  6'sd15; dy = -6'sd6;  end
            4'd2:  begin dx =  6'sd11; dy = -6'sd11; end
            4'd3:  begin dx =  6'sd6;  dy = -6'sd15; end
            4'd4:  begin dx =  6'sd0;  dy = -6'sd16; end
            4'd5:  begin dx = -6'sd6;  dy = -6'sd15; end
            4'd6:  begin dx = -6'sd11; dy = -6'sd11; end
            4'd7:  begin dx = -6'sd15; dy = -6'sd6;  end
            4'd8:  begin dx = -6'sd16; dy =  6'sd0;  end
            4'd9:  begin dx = -6'sd15; dy =  6'sd6;  end
            4'd10: begin dx = -6'sd11; dy =  6'sd11; end
            4'd11: begin dx = -6'sd6;  dy =  6'sd15; end
            4'd12: begin dx =  6'sd0;  dy =  6'sd16; end
            4'd13: begin dx =  6'sd6;  dy =  6'sd15; end
            4'd14: begin dx =  6'sd11; dy =  6'sd11; end
            4'd15: begin dx =  6'sd15; dy =  6'sd6;  end
            default: begin dx = 6'sd0; dy = 6'sd0; end
        endcase
    end

endmodule

// File: rtl/ring_line_plotter.sv
// Radial line plotter: latches a direction/length/colour on calc, then on
// draw rasterises centre-to-endpoint with Bresenham, one pixel per clock.
module ring_line_plotter
    import ring_pkg::*;
#(
    parameter int CX    = 80,
    parameter int CY    = 60,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119,
    parameter int LEN_W = 6
) (
    input  logic clk,
    input  logic reset,
    ring_line_plotter_if.slave bus
);

    localparam logic signed [15:0] CX_S    = 16'(CX);
    localparam logic signed [15:0] CY_S    = 16'(CY);
    localparam logic signed [15:0] X_MAX_S = 16'(X_MAX);
    localparam logic signed [15:0] Y_MAX_S = 16'(Y_MAX);
    localparam logic signed [8:0]  CX9     = 9'(CX);
    localparam logic signed [8:0]  CY9     = 9'(CY);

    logic [1:0]          state;
    logic                armed;
    logic [3:0]          line_q;
    logic [LEN_W-1:0]    len_q;
    logic [COLOUR_W-1:0] col_q;

    logic [X_W-1:0]      cur_x;
    logic [Y_W-1:0]      cur_y;
    logic [X_W-1:0]      adx;
    logic [Y_W-1:0]      ady;
    logic                sx_neg;
    logic                sy_neg;
    logic signed [9:0]   err;

    logic signed [5:0]   dir_dx;
    logic signed [5:0]   dir_dy;
    logic signed [15:0]  len_s;
    logic signed [15:0]  off_x;
    logic signed [15:0]  off_y;
    logic [X_W-1:0]      end_x;
    logic [Y_W-1:0]      end_y;

    logic signed [8:0]   dist_x;
    logic signed [8:0]   dist_y;
    logic [X_W-1:0]      adx_n;
    logic [Y_W-1:0]      ady_n;

    logic signed [9:0]   adx_s;
    logic signed [9:0]   ady_s;
    logic signed [9:0]   e2;
    logic signed [9:0]   nxt_err;
    logic [X_W-1:0]      nxt_x;
    logic [Y_W-1:0]      nxt_y;
    logic                at_end;

    // Saturate a signed screen coordinate into the legal x range
    function automatic logic [X_W-1:0] clip_x(input logic signed [15:0] v);
        if (v < 16'sd0)
            return '0;
        else if (v > X_MAX_S)
            return X_MAX_S[X_W-1:0];
        else
            return v[X_W-1:0];
    endfunction

    // Saturate a signed screen coordinate into the legal y range
    function automatic logic [Y_W-1:0] clip_y(input logic signed [15:0] v);
        if (v < 16'sd0)
            return '0;
        else if (v > Y_MAX_S)
            return Y_MAX_S[Y_W-1:0];
        else
            return v[Y_W-1:0];
    endfunction

    line_dir_rom u_dir_rom (
        .k  (line_q),
        .dx (dir_dx),
        .dy (dir_dy)
    );

    // Endpoint derived from the latched line: scale, floor-shift, offset, clip
    always_comb begin
        len_s = signed'(16'(len_q));
        off_x = (16'(dir_dx) * len_s) >>> SCALE_SHIFT;
        off_y = (16'(dir_dy) * len_s) >>> SCALE_SHIFT;
        end_x = clip_x(CX_S + off_x);
        end_y = clip_y(CY_S + off_y);
    end

    // Absolute distances and step directions loaded at SETUP
    always_comb begin
        dist_x = $signed({1'b0, end_x}) - CX9;
        dist_y = $signed({2'b0, end_y}) - CY9;
        adx_n  = dist_x[8] ? X_W'(-dist_x) : dist_x[X_W-1:0];
        ady_n  = dist_y[8] ? Y_W'(-dist_y) : dist_y[Y_W-1:0];
    end

    // One Bresenham step; x and y moves are decided from the same e2
    always_comb begin
        adx_s   = $signed({2'b0, adx});
        ady_s   = $signed({3'b0, ady});
        e2      = err <<< 1;
        nxt_err = err;
        nxt_x   = cur_x;
        nxt_y   = cur_y;
        if (e2 > -ady_s) begin
            nxt_err = nxt_err - ady_s;
            nxt_x   = sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
        end
        if (e2 < adx_s) begin
            nxt_err = nxt_err + adx_s;
            nxt_y   = sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
        end
        at_end = (cur_x == end_x) && (cur_y == end_y);
    end

    // Control FSM, latched line parameters and Bresenham state
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            armed  <= 1'b1;
            line_q <= '0;
            len_q  <= '0;
            col_q  <= '0;
            cur_x  <= X_W'(CX);
            cur_y  <= Y_W'(CY);
            adx    <= '0;
            ady    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            err    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.calc) begin
                        line_q <= bus.line_number;
                        len_q  <= bus.length;
                        col_q  <= bus.colour_in;
                        armed  <= 1'b1;
                    end else if (!bus.draw) begin
                        armed  <= 1'b1;
                    end
                    if (bus.draw && armed)
                        state <= ST_SETUP;
                end
                ST_SETUP: begin
                    cur_x  <= X_W'(CX);
                    cur_y  <= Y_W'(CY);
                    adx    <= adx_n;
                    ady    <= ady_n;
                    sx_neg <= dist_x[8];
                    sy_neg <= dist_y[8];
                    err    <= $signed({2'b0, adx_n}) - $signed({3'b0, ady_n});
                    state  <= ST_PLOT;
                end
                ST_PLOT: begin
                    if (at_end) begin
                        armed <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        cur_x <= nxt_x;
                        cur_y <= nxt_y;
                        err   <= nxt_err;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // busy rises combinationally with the first accepted draw cycle
    always_comb begin
        bus.busy       = (state != ST_IDLE) || (bus.draw && armed && (state == ST_IDLE));
        bus.plot       = (state == ST_PLOT);
        bus.x          = cur_x;
        bus.y          = cur_y;
        bus.colour_out = col_q;
    end

endmodule
